// File: rtl/jalu_seq.sv
// Sequential jALU: valid/ready operand handshake, registered result/flags, multi-cycle shift-by-N.
// Optional iterative shift-add multiplier (opcode 10) when JALU_MUL_EN is defined.
module jalu_seq #(
  parameter int N = 8
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         wiv,
  output logic         wir,
  input  logic [N-1:0] bas,
  input  logic [N-1:0] bbs,
  input  logic         wci,
  input  logic [3:0]   bops,
  output logic         wov,
  input  logic         woa,
  output logic [N-1:0] bcs,
  output logic [N-1:0] bhs,
  output logic         wco,
  output logic         weqo,
  output logic         walo,
  output logic         wz,
  output logic         werr
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SHR = 4'd1, OP_SHL = 4'd2, OP_NOT = 4'd3,
                         OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_CMP = 4'd7,
                         OP_SHRN = 4'd8, OP_SHLN = 4'd9;
`ifdef JALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;

  logic [N-1:0]  ra, rb, w;
  logic          ci;
  logic [3:0]    op;
  logic [CW-1:0] cnt;
  logic          go, last;

  // single-cycle result, computed straight from the operand bus at accept
  logic [N-1:0] c_res;
  logic         c_co, c_err, c_multi;

  always_comb begin
    c_res = '0; c_co = 1'b0; c_err = 1'b0; c_multi = 1'b0;
    case (bops)
      OP_ADD:  {c_co, c_res} = {1'b0, bas} + {1'b0, bbs} + {{N{1'b0}}, wci};
      OP_SHR:  begin c_res = {wci, bas[N-1:1]}; c_co = bas[0];   end
      OP_SHL:  begin c_res = {bas[N-2:0], wci}; c_co = bas[N-1]; end
      OP_NOT:  c_res = ~bas;
      OP_AND:  c_res = bas & bbs;
      OP_OR:   c_res = bas | bbs;
      OP_XOR:  c_res = bas ^ bbs;
      OP_CMP:  c_res = '0;
      OP_SHRN, OP_SHLN: begin c_res = bas; c_multi = (bbs[SW-1:0] != '0); end
`ifdef JALU_MUL_EN
      OP_MUL:  c_multi = 1'b1;
`endif
      default: c_err = 1'b1;
    endcase
  end

  // one BUSY step; for MUL {wh,w} is the shifting {partial product, multiplier}
  logic [N-1:0] s_lo;
  logic         s_co;
`ifdef JALU_MUL_EN
  logic [N-1:0] wh, s_hi;
  logic [N:0]   sum;
`endif

  always_comb begin
    s_lo = w; s_co = 1'b0;
`ifdef JALU_MUL_EN
    s_hi = wh;
    sum  = {1'b0, wh} + (w[0] ? {1'b0, ra} : '0);
`endif
    case (op)
      OP_SHRN: begin s_lo = {ci, w[N-1:1]}; s_co = w[0];   end
      OP_SHLN: begin s_lo = {w[N-2:0], ci}; s_co = w[N-1]; end
`ifdef JALU_MUL_EN
      OP_MUL:  {s_hi, s_lo} = {sum, w[N-1:1]};
`endif
      default: ;
    endcase
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge wclk or posedge wrst)
    if (wrst) state <= IDLE;
    else      state <= nxt;

  always_comb begin
    nxt = state; wir = 1'b0; wov = 1'b0;
    case (state)
      IDLE:    wir = 1'b1;
      BUSY:    if (last) nxt = DONE;
      DONE:    begin wov = 1'b1; wir = woa; if (woa) nxt = IDLE; end
      default: nxt = IDLE;
    endcase
    go = wir & wiv;
    if (go) nxt = c_multi ? BUSY : DONE;
  end

  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      ra <= '0; rb <= '0; w <= '0; ci <= 1'b0; op <= '0; cnt <= '0;
      bcs <= '0; wco <= 1'b0; weqo <= 1'b0; walo <= 1'b0; wz <= 1'b0; werr <= 1'b0;
`ifdef JALU_MUL_EN
      wh <= '0; bhs <= '0;
`endif
    end else if (go) begin
      ra <= bas; rb <= bbs; ci <= wci; op <= bops; w <= bas;
      cnt <= CW'(bbs[SW-1:0]);
`ifdef JALU_MUL_EN
      wh <= '0;
      if (bops == OP_MUL) begin w <= bbs; cnt <= CW'(N); end
`endif
      if (!c_multi) begin
        bcs <= c_res; wco <= c_co; werr <= c_err; wz <= (c_res == '0);
        weqo <= (bas == bbs); walo <= (bas > bbs);
`ifdef JALU_MUL_EN
        bhs <= '0;
`endif
      end
    end else if (state == BUSY) begin
      w <= s_lo; cnt <= cnt - CW'(1);
`ifdef JALU_MUL_EN
      wh <= s_hi;
`endif
      if (last) begin
        bcs <= s_lo; wco <= s_co; werr <= 1'b0;
        weqo <= (ra == rb); walo <= (ra > rb);
`ifdef JALU_MUL_EN
        bhs <= s_hi; wz <= (s_lo == '0) && (s_hi == '0);
`else
        wz <= (s_lo == '0);
`endif
      end
    end

`ifndef JALU_MUL_EN
  assign bhs = '0;
`endif
endmodule

// File: tb/tb_jalu_seq.sv
// Directed bench for jalu_seq (N=8): hand-computed vectors, latency, handshake and reset abort.
module tb_jalu_seq;
  localparam int N = 8;
  logic wclk = 1'b0;
  logic wrst, wiv, wir, wci, wov, woa, wco, weqo, walo, wz, werr;
  logic [N-1:0] bas, bbs, bcs, bhs;
  logic [3:0] bops;
  int checks = 0, errors = 0, lat;
  logic wir_busy;

  always #5 wclk = ~wclk;

  jalu_seq #(.N(N)) dut (
    .wclk(wclk), .wrst(wrst), .wiv(wiv), .wir(wir), .bas(bas), .bbs(bbs), .wci(wci),
    .bops(bops), .wov(wov), .woa(woa), .bcs(bcs), .bhs(bhs), .wco(wco), .weqo(weqo),
    .walo(walo), .wz(wz), .werr(werr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issue one op, then wait (bounded) for wov; lat = clocks from accept to wov
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [3:0] op);
    @(negedge wclk); bas = a; bbs = b; wci = c; bops = op; wiv = 1'b1;
    @(posedge wclk); @(negedge wclk); wiv = 1'b0; lat = 1; wir_busy = 1'b0;
    while (!wov && lat < 64) begin
      wir_busy |= wir;
      @(negedge wclk); lat++;
    end
  endtask

  task automatic ack();
    @(negedge wclk); woa = 1'b1;
    @(posedge wclk); #1 woa = 1'b0;
  endtask

  task automatic res(input string tag, input int elat, input logic [7:0] ebcs, input logic eco,
                     input logic eeq, input logic eal, input logic ez, input logic eerr);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".bcs"}, bcs, ebcs);
    chk({tag, ".wco"}, wco, eco);
    chk({tag, ".weqo"}, weqo, eeq);
    chk({tag, ".walo"}, walo, eal);
    chk({tag, ".wz"}, wz, ez);
    chk({tag, ".werr"}, werr, eerr);
  endtask

  initial begin
    wrst = 1'b1; wiv = 1'b0; woa = 1'b0; wci = 1'b0; bas = '0; bbs = '0; bops = '0;
    repeat (2) @(negedge wclk);
    wrst = 1'b0;
    @(negedge wclk);
    chk("rst.wir", wir, 1); chk("rst.wov", wov, 0);
    chk("rst.out", {bcs, bhs, wco, weqo, walo, wz, werr}, 0);

    run(8'hFF, 8'h01, 1'b0, 4'd0);  res("add_ff", 1, 8'h00, 1, 0, 1, 1, 0); ack();
    run(8'h7F, 8'h00, 1'b1, 4'd0);  res("add_ci", 1, 8'h80, 0, 0, 1, 0, 0); ack();
    run(8'h81, 8'h03, 1'b1, 4'd9);  res("shln3", 4, 8'h0F, 0, 0, 1, 0, 0);
    chk("shln3.wir_busy", wir_busy, 0); ack();
    run(8'h5A, 8'h5A, 1'b0, 4'd7);  res("cmp_eq", 1, 8'h00, 0, 1, 0, 1, 0); ack();
    run(8'h33, 8'h11, 1'b0, 4'd12); res("ill12", 1, 8'h00, 0, 0, 1, 1, 1); ack();
    run(8'h81, 8'h90, 1'b0, 4'd1);  res("shr", 1, 8'h40, 1, 0, 0, 0, 0); ack();
    run(8'h81, 8'h00, 1'b1, 4'd2);  res("shl", 1, 8'h03, 1, 0, 1, 0, 0); ack();
    run(8'h0F, 8'h00, 1'b0, 4'd3);  res("not", 1, 8'hF0, 0, 0, 1, 0, 0); ack();
    run(8'hF0, 8'h0F, 1'b0, 4'd5);  res("or", 1, 8'hFF, 0, 0, 1, 0, 0); ack();
    // count field is bbs[2:0] only; upper bits still feed the compare
    run(8'h80, 8'h08, 1'b1, 4'd8);  res("shrn0", 1, 8'h80, 0, 0, 1, 0, 0); ack();
    run(8'hC1, 8'h07, 1'b0, 4'd8);  res("shrn7", 8, 8'h01, 1, 0, 1, 0, 0); ack();
    run(8'hF0, 8'hF0, 1'b0, 4'd15); res("ill15", 1, 8'h00, 0, 1, 0, 1, 1); ack();

    // hold in DONE, then back-to-back accept
    run(8'hF0, 8'h3C, 1'b0, 4'd4);  res("and", 1, 8'h30, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      chk("hold.wov", wov, 1); chk("hold.bcs", bcs, 8'h30); chk("hold.wir", wir, 0);
    end
    @(negedge wclk); woa = 1'b1; wiv = 1'b1; bas = 8'h0F; bbs = 8'hFF; bops = 4'd6;
    #1 chk("b2b.wir", wir, 1);
    @(posedge wclk); @(negedge wclk); woa = 1'b0; wiv = 1'b0;
    chk("b2b.wov", wov, 1); chk("b2b.bcs", bcs, 8'hF0); chk("b2b.wz", wz, 0);
    ack();

`ifdef JALU_MUL_EN
    run(8'hFF, 8'hFF, 1'b0, 4'd10); res("mul", 9, 8'h01, 0, 1, 0, 0, 0);
    chk("mul.bhs", bhs, 8'hFE); ack();
    run(8'h00, 8'h37, 1'b0, 4'd10); res("mul0", 9, 8'h00, 0, 0, 0, 1, 0);
    chk("mul0.bhs", bhs, 8'h00); ack();
`else
    run(8'hFF, 8'hFF, 1'b0, 4'd10); res("mul_off", 1, 8'h00, 0, 1, 0, 1, 1);
    chk("mul_off.bhs", bhs, 8'h00); ack();
`endif

    // reset in the middle of a long shift; outputs still hold the prior op (0F)
    run(8'hF0, 8'hFF, 1'b0, 4'd3); ack();
    @(negedge wclk); bas = 8'hC1; bbs = 8'h07; wci = 1'b1; bops = 4'd8; wiv = 1'b1;
    @(posedge wclk); @(negedge wclk); wiv = 1'b0;
    repeat (2) @(negedge wclk);
    chk("abort.busy_wir", wir, 0); chk("abort.busy_wov", wov, 0);
    wrst = 1'b1;
    #1;
    chk("abort.wir", wir, 1); chk("abort.wov", wov, 0);
    chk("abort.out", {bcs, bhs, wco, weqo, walo, wz, werr}, 0);
    @(negedge wclk); wrst = 1'b0;
    repeat (10) @(negedge wclk);
    chk("abort.idle_wov", wov, 0); chk("abort.idle_wir", wir, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
